// File: rtl/seq_pkg.sv
// Shared state/mode encodings and helpers for the LED pattern sequencer.
package seq_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_SHIFT     = 3'd0,
    S_BOUNCE_UP = 3'd1,
    S_BOUNCE_DN = 3'd2,
    S_FILL      = 3'd3,
    S_BLINK_ON  = 3'd4,
    S_BLINK_OFF = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  function automatic mode_t mode_of(input state_t s);
    case (s)
      S_BOUNCE_UP, S_BOUNCE_DN: mode_of = MODE_BOUNCE;
      S_FILL:                   mode_of = MODE_FILL;
      S_BLINK_ON, S_BLINK_OFF:  mode_of = MODE_BLINK;
      default:                  mode_of = MODE_SHIFT;
    endcase
  endfunction

  function automatic state_t entry_state(input mode_t m);
    case (m)
      MODE_BOUNCE: entry_state = S_BOUNCE_UP;
      MODE_FILL:   entry_state = S_FILL;
      MODE_BLINK:  entry_state = S_BLINK_ON;
      default:     entry_state = S_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronises a raw push button and accepts a new level after DEB_SAMPLES equal tick_mf samples.
// btn_rise is a registered 1-cycle pulse the cycle after a 0->1 level is accepted.
module btn_debouncer
  import seq_pkg::*;
#(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick_mf,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_rise
);

  localparam int CW = $clog2(DEB_SAMPLES) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      btn_db   <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      btn_rise <= 1'b0;
      if (tick_mf) begin
        // A sample matching the accepted level restarts the run of differing samples.
        if (btn_s == btn_db) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_SAMPLES - 1)) begin
          btn_db   <= btn_s;
          btn_rise <= btn_s;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/moore_sequencer.sv
// Moore LED pattern sequencer: one step per tick_lf (unless paused), mode cycles on debounced button.
// leds/mode are registered, 1-cycle after the strobe; SEQ_STEP_CNT_EN adds the step_count port.
module moore_sequencer
  import seq_pkg::*;
#(
  parameter int N_LEDS      = 8,
  parameter int DEB_SAMPLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              tick_mf,
  input  logic              tick_lf,
  input  logic              btn_mode,
  input  logic              sw_dir,
  input  logic              sw_pause,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        mode
`ifdef SEQ_STEP_CNT_EN
  ,
  output logic [CNT_W-1:0]  step_count
`endif
);

  localparam int PW = $clog2(N_LEDS + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(N_LEDS);

  if (N_LEDS < 2 || DEB_SAMPLES < 2 || CNT_W < 1) begin : g_bad_param
    $error("moore_sequencer: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_core_n;
  logic [SYNC_STAGES-1:0] dir_sync_q;
  logic [SYNC_STAGES-1:0] pause_sync_q;
  logic                   dir_s;
  logic                   pause_s;
  logic                   btn_level;
  logic                   btn_rise;
  logic                   press;
  logic                   step;

  state_t            state_q, state_nxt;
  logic [PW-1:0]     pos_q, pos_nxt;
  logic [N_LEDS-1:0] leds_nxt;
  logic [1:0]        mode_inc;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_core_n = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rst_core_n) begin
    if (!rst_core_n) begin
      dir_sync_q   <= '0;
      pause_sync_q <= '0;
    end else begin
      dir_sync_q   <= {dir_sync_q[SYNC_STAGES-2:0], sw_dir};
      pause_sync_q <= {pause_sync_q[SYNC_STAGES-2:0], sw_pause};
    end
  end
  assign dir_s   = dir_sync_q[SYNC_STAGES-1];
  assign pause_s = pause_sync_q[SYNC_STAGES-1];

  btn_debouncer #(
    .DEB_SAMPLES(DEB_SAMPLES)
  ) u_btn_debouncer (
    .clk_in  (clk_in),
    .rst_n   (rst_core_n),
    .tick_mf (tick_mf),
    .btn_raw (btn_mode),
    .btn_db  (btn_level),
    .btn_rise(btn_rise)
  );

  assign press = btn_rise & btn_level;
  assign step  = tick_lf & ~pause_s;

  always_comb begin
    state_nxt = state_q;
    pos_nxt   = pos_q;
    mode_inc  = mode_of(state_q) + 2'd1;
    case (state_q)
      S_SHIFT: if (step) begin
        if (dir_s) pos_nxt = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
        else       pos_nxt = (pos_q >= POS_LAST) ? '0 : pos_q + PW'(1);
      end
      S_BOUNCE_UP: if (step) begin
        if (pos_q >= POS_LAST) begin
          state_nxt = S_BOUNCE_DN;
          pos_nxt   = POS_LAST - PW'(1);
        end else begin
          pos_nxt = pos_q + PW'(1);
        end
      end
      S_BOUNCE_DN: if (step) begin
        if (pos_q == '0) begin
          state_nxt = S_BOUNCE_UP;
          pos_nxt   = PW'(1);
        end else begin
          pos_nxt = pos_q - PW'(1);
        end
      end
      S_FILL: if (step) begin
        if (dir_s) pos_nxt = (pos_q == '0) ? POS_FULL : pos_q - PW'(1);
        else       pos_nxt = (pos_q >= POS_FULL) ? '0 : pos_q + PW'(1);
      end
      S_BLINK_ON:  if (step) state_nxt = S_BLINK_OFF;
      S_BLINK_OFF: if (step) state_nxt = S_BLINK_ON;
      default: begin
        state_nxt = S_SHIFT;
        pos_nxt   = '0;
      end
    endcase
    // A mode press overrides any step taken in the same cycle.
    if (press) begin
      state_nxt = entry_state(mode_t'(mode_inc));
      pos_nxt   = '0;
    end
  end

  always_comb begin
    leds_nxt = '0;
    case (state_nxt)
      S_SHIFT, S_BOUNCE_UP, S_BOUNCE_DN:
        for (int i = 0; i < N_LEDS; i++) leds_nxt[i] = (pos_nxt == PW'(i));
      S_FILL:
        for (int i = 0; i < N_LEDS; i++) leds_nxt[i] = (PW'(i) < pos_nxt);
      S_BLINK_ON: leds_nxt = '1;
      default:    leds_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q <= S_SHIFT;
      pos_q   <= '0;
      leds    <= N_LEDS'(1);
      mode    <= MODE_SHIFT;
    end else begin
      state_q <= state_nxt;
      pos_q   <= pos_nxt;
      leds    <= leds_nxt;
      mode    <= mode_of(state_nxt);
    end
  end

`ifdef SEQ_STEP_CNT_EN
  always_ff @(posedge clk_in or negedge rst_core_n) begin
    if (!rst_core_n)          step_count <= '0;
    else if (step && !press)  step_count <= step_count + CNT_W'(1);
  end
`endif

endmodule
